mem_port_arbiter: RTL and testbench

// Shares the single-port data memory of the multiplier datapath between two requesters:

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous single-port data memory (1-cycle read latency)
// between two requesters: port 0 is the multiplier controller, port 1 is the
// host loader/dumper. Arbitration is per cycle and round-robin on the most
// recently granted port. A requester may assert lockN to keep ownership for a
// burst. While the other port waits, that ownership is bounded to MAX_HOLD
// consecutive grants.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req0/1                access request, held until granted
//   we0/1                 1 = write, 0 = read
//   lock0/1               keep ownership after this access
//   addr0/1, wdata0/1     access address / write data
//   gnt0/1                access issued this cycle (combinational)
//   rvalid0/1, rdata0/1   read data return, one cycle after a granted read;
//                         rdataN holds until that port's next read returns
//   mem_en, mem_we        memory strobe / write enable
//   mem_addr, mem_wdata   memory address / write data
//   mem_rdata             memory read data, valid the cycle after a read strobe
module mem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              pend0_q, pend1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              hold_ok;

  function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] h);
    return (h == HW'(MAX_HOLD)) ? h : h + 1'b1;
  endfunction

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    last_d  = last_q;
    hold_d  = '0;
    hold_ok = (hold_q < HW'(MAX_HOLD));

    // A locked owner keeps the port unless it has used up its hold budget
    // while the other side waits; then it falls to plain round-robin, where
    // last == owner hands the cycle to the waiting port.
    if (state_q == OWN0 && req0 && (!req1 || hold_ok)) begin
      gnt0 = 1'b1;
    end else if (state_q == OWN1 && req1 && (!req0 || hold_ok)) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (last_q) gnt0 = 1'b1;
      else        gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end

    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      last_d = 1'b0;
      if (lock0) begin
        state_d = OWN0;
        hold_d  = (state_q == OWN0) ? hold_inc(hold_q) : HW'(1);
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      if (lock1) begin
        state_d = OWN1;
        hold_d  = (state_q == OWN1) ? hold_inc(hold_q) : HW'(1);
      end
    end
  end

  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  // Read return: the pending flag marks the cycle mem_rdata is valid. Reset
  // masks it immediately so a read in flight never surfaces.
  assign rvalid0 = pend0_q & ~rst;
  assign rvalid1 = pend1_q & ~rst;
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      hold_q   <= '0;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pend0_q <= gnt0 & ~we0;
      pend1_q <= gnt1 & ~we1;
      if (pend0_q) rdata0_q <= mem_rdata;
      if (pend1_q) rdata1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem   [16];
  logic [DW-1:0] model [16];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          no_push = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: every cycle, each port either delivers the oldest
  // expected read or stays quiet.
  always @(posedge clk) begin
    logic [DW-1:0] e;
    #3;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("rvalid0", {31'b0, rvalid0}, 32'd1);
      check("rdata0", {16'b0, rdata0}, {16'b0, e});
    end else check("rvalid0_quiet", {31'b0, rvalid0}, 32'd0);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("rvalid1", {31'b0, rvalid1}, 32'd1);
      check("rdata1", {16'b0, rdata1}, {16'b0, e});
    end else check("rvalid1_quiet", {31'b0, rvalid1}, 32'd0);
  end

  task automatic drv0(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  // One cycle: inputs already driven at posedge+1; check at negedge.
  task automatic step(input logic eg0, input logic eg1);
    @(negedge clk);
    check("gnt0", {31'b0, gnt0}, {31'b0, eg0});
    check("gnt1", {31'b0, gnt1}, {31'b0, eg1});
    check("mem_en", {31'b0, mem_en}, {31'b0, eg0 | eg1});
    if (eg0) begin
      check("mem_we", {31'b0, mem_we}, {31'b0, we0});
      check("mem_addr", {28'b0, mem_addr}, {28'b0, addr0});
      if (we0) begin
        check("mem_wdata", {16'b0, mem_wdata}, {16'b0, wdata0});
        model[addr0] = wdata0;
      end else if (!no_push) q0.push_back(model[addr0]);
    end else if (eg1) begin
      check("mem_we", {31'b0, mem_we}, {31'b0, we1});
      check("mem_addr", {28'b0, mem_addr}, {28'b0, addr1});
      if (we1) begin
        check("mem_wdata", {16'b0, mem_wdata}, {16'b0, wdata1});
        model[addr1] = wdata1;
      end else if (!no_push) q1.push_back(model[addr1]);
    end else begin
      check("mem_we_idle", {31'b0, mem_we}, 32'd0);
      check("mem_addr_idle", {28'b0, mem_addr}, 32'd0);
      check("mem_wdata_idle", {16'b0, mem_wdata}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_both();
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_both();
    step(0, 0);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 16'h1000 + 16'(i) * 16'h0111;
      model[i] = 16'h1000 + 16'(i) * 16'h0111;
    end
    mem[3] = 16'h00A5; model[3] = 16'h00A5;
    rst = 1'b1;
    idle_both();
    @(posedge clk); #1;

    // Reset: outputs gated even with live requests.
    drv0(1, 1, 0, 4'h9, 16'hBEEF);
    drv1(1, 0, 0, 4'h2, 16'h0);
    step(0, 0);
    idle_both();
    step(0, 0);
    rst = 1'b0;

    // 1: single read of mem[3].
    drv0(1, 0, 0, 3, 0);
    step(1, 0);
    idle_both();
    step(0, 0);
    check("rdata0_hold", {16'b0, rdata0}, 32'h00A5);

    // 2: both requesting, no lock -> 0,1,0,1.
    do_reset();
    drv0(1, 0, 0, 1, 0);
    drv1(1, 0, 0, 2, 0);
    step(1, 0); step(0, 1); step(1, 0); step(0, 1);

    // 3: port 0 locked, port 1 waiting: four grants to 0, then 1, then 0.
    do_reset();
    drv0(1, 0, 1, 4, 0);
    drv1(1, 0, 0, 5, 0);
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    step(0, 1);
    step(1, 0);

    // 4: lock0 for two grants, then dropped while port 1 waits.
    do_reset();
    drv0(1, 0, 1, 4, 0);
    drv1(1, 0, 0, 5, 0);
    step(1, 0); step(1, 0);
    lock0 = 1'b0;
    step(1, 0);
    step(0, 1);

    // 5: port 1 writes addr 7, port 0 reads it back.
    idle_both();
    step(0, 0);
    drv1(1, 1, 0, 7, 16'h1234);
    step(0, 1);
    idle_both();
    drv0(1, 0, 0, 7, 0);
    step(1, 0);
    idle_both();
    step(0, 0);
    check("mem7", {16'b0, mem[7]}, 32'h1234);

    // 6: reset right after a granted read suppresses its return.
    drv0(1, 0, 0, 3, 0);
    no_push = 1'b1;
    step(1, 0);
    no_push = 1'b0;
    idle_both();
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    drv0(1, 0, 0, 1, 0);
    drv1(1, 0, 0, 2, 0);
    check("rdata0_after_rst", {16'b0, rdata0}, 32'd0);
    step(1, 0);
    idle_both();
    step(0, 0);
    step(0, 0);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
